// File: rtl/seq_divider_n.sv
// ---------------------------------------------------------------------------
// seq_divider_n
//   Unsigned sequential restoring divider with a normalised divisor.
//   The divisor is shifted left so its MSB sits at bit WIDTH-1. Only the
//   quotient bits that can be non-zero are then computed. Latency is
//   WIDTH - msb(divisor) cycles, or 1 cycle for a zero divisor.
//
// Ports
//   clk_in       in   1      clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   start        in   1      request; accepted only while busy==0
//   dividend     in   WIDTH  numerator, sampled on the accept edge
//   divisor      in   WIDTH  denominator, sampled on the accept edge
//   busy         out  1      high from the accept edge until completion
//   done         out  1      one-cycle completion pulse
//   quotient     out  WIDTH  result, held until the next accept
//   remainder    out  WIDTH  result, held until the next accept
//   div_by_zero  out  1      set with done for a zero divisor; cleared on accept
// ---------------------------------------------------------------------------
module seq_divider_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   rem, rem_nxt;
  logic [WIDTH-1:0]   dvs, dvs_nxt;
  logic [WIDTH-1:0]   q, q_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               zdiv, zdiv_nxt;     // current operation has a zero divisor
  logic               busy_nxt, done_nxt, dz_nxt;
  logic [WIDTH-1:0]   quotient_nxt, remainder_nxt;

  logic [CNT_W-1:0]   msb;                // highest set bit of divisor
  logic [CNT_W-1:0]   shift_d;            // normalising shift amount
  logic [WIDTH-1:0]   dvs_norm;
  logic               ge;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   q_step;

  // Priority encoder: the last assignment in the upward loop wins, so msb
  // ends up as the highest set bit. A zero divisor leaves msb at 0, which is
  // harmless because that case bypasses the iteration entirely.
  always_comb begin
    msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (divisor[i]) msb = CNT_W'(i);
    end
  end

  assign shift_d  = CNT_W'(WIDTH - 1) - msb;
  assign dvs_norm = divisor << shift_d;

  // One restoring step. Subtraction happens only when rem >= dvs, so it never wraps.
  assign ge       = (rem >= dvs);
  assign rem_step = ge ? (rem - dvs) : rem;
  assign q_step   = {q[WIDTH-2:0], ge};

  always_comb begin
    // NOTE: every signal written here gets a default first. An assignment
    // missing on some path would otherwise infer a latch.
    state_nxt     = state;
    rem_nxt       = rem;
    dvs_nxt       = dvs;
    q_nxt         = q;
    cnt_nxt       = cnt;
    zdiv_nxt      = zdiv;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    dz_nxt        = div_by_zero;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;

    unique case (state)
      IDLE: begin
        if (start) begin
          rem_nxt   = dividend;
          q_nxt     = '0;
          dz_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = CALC;
          if (divisor == '0) begin
            zdiv_nxt = 1'b1;
            dvs_nxt  = '0;
            cnt_nxt  = CNT_W'(1);
          end else begin
            zdiv_nxt = 1'b0;
            dvs_nxt  = dvs_norm;
            cnt_nxt  = shift_d + CNT_W'(1);
          end
        end
      end

      CALC: begin
        if (zdiv) begin
          // Zero divisor: report all-ones / dividend after a single cycle.
          quotient_nxt  = '1;
          remainder_nxt = rem;
          dz_nxt        = 1'b1;
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          cnt_nxt       = '0;
          zdiv_nxt      = 1'b0;
          state_nxt     = IDLE;
        end else begin
          q_nxt   = q_step;
          rem_nxt = rem_step;
          dvs_nxt = dvs >> 1;
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            quotient_nxt  = q_step;
            remainder_nxt = rem_step;
            done_nxt      = 1'b1;
            busy_nxt      = 1'b0;
            state_nxt     = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      dvs         <= '0;
      q           <= '0;
      cnt         <= '0;
      zdiv        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      state       <= state_nxt;
      rem         <= rem_nxt;
      dvs         <= dvs_nxt;
      q           <= q_nxt;
      cnt         <= cnt_nxt;
      zdiv        <= zdiv_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      div_by_zero <= dz_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
    end
  end

endmodule

// File: tb/tb_seq_divider_n.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_n
//   Directed bench for seq_divider_n. An 8-bit instance is driven from a
//   vector table and from hand-written handshake and reset sequences. A
//   16-bit instance is compared against the behavioural / and % operators.
// ---------------------------------------------------------------------------
module tb_seq_divider_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   t_acc8, t_acc16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 8-bit instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, dz8;
  logic [7:0] q8, r8;

  seq_divider_n #(.WIDTH(8)) u8 (
    .clk_in(clk), .rst(rst), .start(start8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
    .div_by_zero(dz8)
  );

  // 16-bit instance
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, dz16;
  logic [15:0] q16, r16;

  seq_divider_n #(.WIDTH(16)) u16 (
    .clk_in(clk), .rst(rst), .start(start16), .dividend(a16), .divisor(b16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16),
    .div_by_zero(dz16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic accept8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    t_acc8 = cyc;
  endtask

  // Waits (bounded) for done8 and returns the cycles since the accept edge.
  task automatic wait_done8(output int lat);
    int n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lat = done8 ? (cyc - t_acc8) : -1;
  endtask

  function automatic int msb_of(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int lat;
    int n;
    int done_seen;
    logic [15:0] sa, sb, eq, er;
    int elat;
    logic [15:0] specials[5];

    //       a    b    q    r   dz lat
    vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 6};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
    vecs[2]  = '{8'd5,   8'd200, 8'd0,   8'd5,   1'b0, 1};
    vecs[3]  = '{8'd100, 8'd0,   8'd255, 8'd100, 1'b1, 1};
    vecs[4]  = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 7};
    vecs[5]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 6};
    vecs[6]  = '{8'd128, 8'd128, 8'd1,   8'd0,   1'b0, 1};
    vecs[7]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 1};
    vecs[8]  = '{8'd254, 8'd2,   8'd127, 8'd0,   1'b0, 7};
    vecs[9]  = '{8'd1,   8'd1,   8'd1,   8'd0,   1'b0, 8};
    vecs[10] = '{8'd37,  8'd6,   8'd6,   8'd1,   1'b0, 6};

    // Reset state
    #1;
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst quotient", q8, 0);
    check("rst remainder", r8, 0);
    check("rst dz", dz8, 0);
    check("rst busy16", busy16, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      accept8(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d busy after accept", i), busy8, 1);
      check($sformatf("v%0d dz cleared on accept", i), dz8, 0);
      wait_done8(lat);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d quotient", i), q8, vecs[i].q);
      check($sformatf("v%0d remainder", i), r8, vecs[i].r);
      check($sformatf("v%0d dz", i), dz8, vecs[i].dz);
      check($sformatf("v%0d busy at done", i), busy8, 0);
      @(posedge clk); #1;
      check($sformatf("v%0d done pulse width", i), done8, 0);
      check($sformatf("v%0d quotient held", i), q8, vecs[i].q);
    end

    // start while busy is ignored
    accept8(8'd200, 8'd7);
    @(posedge clk); #1;
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(lat);
    check("ignore latency", lat, 6);
    check("ignore quotient", q8, 28);
    check("ignore remainder", r8, 4);

    // start held through the done cycle gives a back-to-back accept
    accept8(8'd200, 8'd7);
    a8 = 8'd9; b8 = 8'd3; start8 = 1'b1;
    wait_done8(lat);
    check("b2b first latency", lat, 6);
    check("b2b first quotient", q8, 28);
    check("b2b first remainder", r8, 4);
    @(posedge clk); #1;
    start8 = 1'b0;
    t_acc8 = cyc;
    check("b2b busy reasserted", busy8, 1);
    check("b2b done cleared", done8, 0);
    check("b2b held quotient", q8, 28);
    wait_done8(lat);
    check("b2b second latency", lat, 7);
    check("b2b second quotient", q8, 3);
    check("b2b second remainder", r8, 0);

    // Reset mid-CALC aborts the operation
    accept8(8'd255, 8'd1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    check("abort quotient", q8, 0);
    check("abort remainder", r8, 0);
    check("abort dz", dz8, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) done_seen++;
    end
    check("no done after abort", done_seen, 0);
    accept8(8'd17, 8'd4);
    wait_done8(lat);
    check("post-reset latency", lat, 6);
    check("post-reset quotient", q8, 4);
    check("post-reset remainder", r8, 1);

    // 16-bit instance against behavioural operators
    specials = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h0002};
    for (int i = 0; i < 3025; i++) begin
      if (i < 25) begin
        sa = specials[i / 5];
        sb = specials[i % 5];
      end else begin
        sa = 16'($urandom);
        sb = 16'($urandom >> $urandom_range(16, 31));
      end
      if (sb == 16'd0) begin
        eq = 16'hFFFF; er = sa; elat = 1;
      end else begin
        eq = sa / sb; er = sa % sb; elat = 16 - msb_of(sb);
      end
      @(negedge clk);
      a16 = sa; b16 = sb; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      t_acc16 = cyc;
      n = 0;
      while (!done16 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      lat = done16 ? (cyc - t_acc16) : -1;
      check($sformatf("w16 %0d/%0d latency", sa, sb), lat, elat);
      check($sformatf("w16 %0d/%0d quotient", sa, sb), q16, eq);
      check($sformatf("w16 %0d/%0d remainder", sa, sb), r16, er);
      check($sformatf("w16 %0d/%0d dz", sa, sb), dz16, (sb == 16'd0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
